// File: rtl/clock_disp_pkg.sv
// Shared constants for the clock display path.
//   - active-low 7-segment glyphs (bit order g,f,e,d,c,b,a)
//   - BLINK_SEL field encodings
//   - digit slot indices, leftmost (hour tens) first
package clock_disp_pkg;

    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

    typedef enum logic [1:0] {
        BLK_NONE = 2'd0,
        BLK_HOUR = 2'd1,
        BLK_MIN  = 2'd2,
        BLK_SEC  = 2'd3
    } blk_sel_e;

    localparam logic [2:0] DIG_HH   = 3'd0;
    localparam logic [2:0] DIG_HL   = 3'd1;
    localparam logic [2:0] DIG_MH   = 3'd2;
    localparam logic [2:0] DIG_ML   = 3'd3;
    localparam logic [2:0] DIG_SH   = 3'd4;
    localparam logic [2:0] DIG_SL   = 3'd5;
    localparam logic [2:0] DIG_LAST = DIG_SL;

endpackage

// File: rtl/seg7_dec.sv
// BCD to active-low 7-segment decoder. Values above 9 show a dash.
//   bcd : 4-bit digit value
//   seg : active-low segments g,f,e,d,c,b,a
module seg7_dec
    import clock_disp_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/time_disp_scan.sv
// Six-digit multiplexed common-anode display driver for the 24-hour clock.
// Snapshots the time digits once per frame, scans one digit per slot with
// leading blanking, optional hour-tens zero suppression and field blinking.
//   CLK       : system clock
//   RST       : asynchronous reset, active-low
//   HH..SL    : BCD time digits from the counter chain
//   BLINK_SEL : field to blink (none / hours / minutes / seconds)
//   DIGIT     : active-low digit enables, bit 0 = hour tens
//   SEG       : active-low segments, [7]=dp, [6:0]=g..a
module time_disp_scan
    import clock_disp_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYC    = 2,
    parameter int BLINK_FRAMES = 128,
    parameter int LZB          = 1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [1:0] HH,
    input  logic [3:0] HL,
    input  logic [2:0] MH,
    input  logic [3:0] ML,
    input  logic [2:0] SH,
    input  logic [3:0] SL,
    input  logic [1:0] BLINK_SEL,
    output logic [5:0] DIGIT,
    output logic [7:0] SEG
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [PW-1:0] PC_LAST  = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] PC_BLANK = PW'(BLANK_CYC);
    localparam logic [FW-1:0] FR_LAST  = FW'(BLINK_FRAMES - 1);

    logic [PW-1:0] pc;
    logic [2:0]    idx;
    logic [1:0]    snap_hh;
    logic [3:0]    snap_hl;
    logic [2:0]    snap_mh;
    logic [3:0]    snap_ml;
    logic [2:0]    snap_sh;
    logic [3:0]    snap_sl;
    blk_sel_e      sel_q;
    logic [FW-1:0] fcnt;
    logic          phase;

    logic          slot_end;
    logic          frame_end;
    logic          frame_start;
    logic          sel_chg;
    logic [3:0]    cur_bcd;
    logic [6:0]    dec_seg;
    logic          dp_n;
    logic [1:0]    sel_pair;
    logic          blink_hit;
    logic          lz_hit;
    logic [5:0]    digit_d;
    logic [7:0]    seg_d;

    assign slot_end    = (pc == PC_LAST);
    assign frame_end   = slot_end && (idx == DIG_LAST);
    assign frame_start = (pc == '0) && (idx == DIG_HH);
    assign sel_chg     = (BLINK_SEL != sel_q);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            pc  <= '0;
            idx <= DIG_HH;
        end else if (slot_end) begin
            pc  <= '0;
            idx <= (idx == DIG_LAST) ? DIG_HH : idx + 3'd1;
        end else begin
            pc  <= pc + 1'b1;
        end
    end

    // Loaded during the first (always blanked) cycle of the frame, so the
    // whole frame is drawn from one consistent time value.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            snap_hh <= '0;
            snap_hl <= '0;
            snap_mh <= '0;
            snap_ml <= '0;
            snap_sh <= '0;
            snap_sl <= '0;
        end else if (frame_start) begin
            snap_hh <= HH;
            snap_hl <= HL;
            snap_mh <= MH;
            snap_ml <= ML;
            snap_sh <= SH;
            snap_sl <= SL;
        end
    end

    // A selection change restarts the blink cycle in the visible phase so
    // the newly chosen field is never dark right after being picked.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sel_q <= BLK_NONE;
            fcnt  <= '0;
            phase <= 1'b0;
        end else begin
            sel_q <= blk_sel_e'(BLINK_SEL);
            if (sel_chg) begin
                fcnt  <= '0;
                phase <= 1'b0;
            end else if (frame_end) begin
                if (fcnt == FR_LAST) begin
                    fcnt  <= '0;
                    phase <= ~phase;
                end else begin
                    fcnt  <= fcnt + 1'b1;
                end
            end
        end
    end

    always_comb begin
        cur_bcd = 4'd0;
        case (idx)
            DIG_HH:  cur_bcd = {2'b00, snap_hh};
            DIG_HL:  cur_bcd = snap_hl;
            DIG_MH:  cur_bcd = {1'b0, snap_mh};
            DIG_ML:  cur_bcd = snap_ml;
            DIG_SH:  cur_bcd = {1'b0, snap_sh};
            DIG_SL:  cur_bcd = snap_sl;
            default: cur_bcd = 4'd0;
        endcase
    end

    seg7_dec u_dec (
        .bcd (cur_bcd),
        .seg (dec_seg)
    );

    // Slots pair up as (0,1)=hours, (2,3)=minutes, (4,5)=seconds, so the
    // selected pair is BLINK_SEL-1 compared against idx[2:1].
    assign sel_pair  = sel_q - 2'd1;
    assign blink_hit = phase && (sel_q != BLK_NONE) && (sel_pair == idx[2:1]);
    assign lz_hit    = (LZB != 0) && (idx == DIG_HH) && (snap_hh == 2'd0);
    assign dp_n      = !((idx == DIG_HL) || (idx == DIG_ML));

    always_comb begin
        digit_d = 6'h3F;
        seg_d   = 8'hFF;
        if (pc >= PC_BLANK) begin
            digit_d = ~(6'b000001 << idx);
            if (lz_hit) begin
                seg_d = 8'hFF;
            end else if (blink_hit) begin
                seg_d = {dp_n, SEG_OFF};
            end else begin
                seg_d = {dp_n, dec_seg};
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            DIGIT <= 6'h3F;
            SEG   <= 8'hFF;
        end else begin
            DIGIT <= digit_d;
            SEG   <= seg_d;
        end
    end

endmodule

// File: tb/tb_time_disp_scan.sv
module tb_time_disp_scan;

    localparam int SD = 4;
    localparam int BC = 1;
    localparam int BF = 2;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [1:0] HH = '0;
    logic [3:0] HL = '0;
    logic [2:0] MH = '0;
    logic [3:0] ML = '0;
    logic [2:0] SH = '0;
    logic [3:0] SL = '0;
    logic [1:0] BLINK_SEL = '0;
    logic [5:0] DIGIT;
    logic [7:0] SEG;

    int checks   = 0;
    int failures = 0;

    // reference model state: cycles since reset release, frame snapshot,
    // frames elapsed since the blink selection last changed
    int n;
    int snap [6];
    int frames_since;
    int msel;
    int last_pos;
    int last_slot;

    time_disp_scan #(
        .SCAN_DIV     (SD),
        .BLANK_CYC    (BC),
        .BLINK_FRAMES (BF),
        .LZB          (1)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .HH        (HH),
        .HL        (HL),
        .MH        (MH),
        .ML        (ML),
        .SH        (SH),
        .SL        (SL),
        .BLINK_SEL (BLINK_SEL),
        .DIGIT     (DIGIT),
        .SEG       (SEG)
    );

    always #5 CLK = ~CLK;

    function automatic logic [6:0] glyph(int v);
        case (v)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    function automatic void model_out(output logic [5:0] d, output logic [7:0] s);
        int  pos  = n % SD;
        int  slot = (n / SD) % 6;
        logic dp;
        logic dark;
        d = 6'h3F;
        s = 8'hFF;
        if (pos >= BC) begin
            d    = 6'h3F ^ (6'd1 << slot);
            dp   = (slot == 1 || slot == 3) ? 1'b0 : 1'b1;
            dark = (((frames_since / BF) % 2) == 1) && (msel == slot / 2 + 1);
            if (slot == 0 && snap[0] == 0) s = 8'hFF;
            else if (dark)                 s = {dp, 7'h7F};
            else                           s = {dp, glyph(snap[slot])};
        end
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h n=%0d", tag, obs, exp, n);
        end
    endtask

    task automatic model_reset();
        n = 0;
        frames_since = 0;
        msel = 0;
        for (int i = 0; i < 6; i++) snap[i] = 0;
    endtask

    task automatic tick();
        logic [5:0] ed;
        logic [7:0] es;
        int pos;
        int slot;
        model_out(ed, es);
        pos  = n % SD;
        slot = (n / SD) % 6;
        if (pos == 0 && slot == 0) begin
            snap[0] = int'(HH); snap[1] = int'(HL); snap[2] = int'(MH);
            snap[3] = int'(ML); snap[4] = int'(SH); snap[5] = int'(SL);
        end
        if (int'(BLINK_SEL) != msel) frames_since = 0;
        else if (pos == SD - 1 && slot == 5) frames_since++;
        msel      = int'(BLINK_SEL);
        last_pos  = pos;
        last_slot = slot;
        n++;
        @(posedge CLK);
        #1;
        chk("digit", {2'b00, DIGIT}, {2'b00, ed});
        chk("seg", SEG, es);
    endtask

    // advance at least one cycle until the outputs show (slot, pos)
    task automatic run_to(input int slot, input int pos);
        int  budget = 200;
        logic found = 1'b0;
        do begin
            tick();
            budget--;
            if (last_slot == slot && last_pos == pos) found = 1'b1;
        end while (!found && budget > 0);
        checks++;
        assert (found) else begin
            failures++;
            $error("FAIL run_to_timeout observed=%0d expected=1", found);
        end
    endtask

    task automatic set_time(input int hh, input int hl, input int mh, input int ml,
                            input int sh, input int sl);
        HH = 2'(hh); HL = 4'(hl); MH = 3'(mh); ML = 4'(ml); SH = 3'(sh); SL = 4'(sl);
    endtask

    initial begin
        model_reset();
        set_time(1, 2, 3, 4, 5, 6);
        BLINK_SEL = 2'd0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_digit", {2'b00, DIGIT}, 8'h3F);
        chk("rst_seg", SEG, 8'hFF);
        @(negedge CLK);
        RST = 1'b1;

        // first frame 12:34:56
        run_to(0, 2);
        chk("f1_s0_seg", SEG, 8'b1_1111001);
        chk("f1_s0_dig", {2'b00, DIGIT}, 8'b00_111110);
        run_to(1, 2);
        chk("f1_s1_seg", SEG, 8'b0_0100100);
        run_to(3, 1);
        chk("f1_s3_seg", SEG, 8'b0_0011001);
        run_to(5, 3);
        chk("f1_s5_seg", SEG, 8'b1_0000010);
        chk("f1_s5_dig", {2'b00, DIGIT}, 8'b00_011111);

        // leading-zero suppression 05:00:00
        set_time(0, 5, 0, 0, 0, 0);
        run_to(0, 2);
        chk("lz_dig", {2'b00, DIGIT}, 8'b00_111110);
        chk("lz_seg", SEG, 8'hFF);
        run_to(1, 2);
        chk("lz_s1_seg", SEG, 8'b0_0010010);
        run_to(5, 3);

        // mid-frame change is deferred to the next frame
        set_time(1, 2, 3, 4, 5, 6);
        run_to(5, 3);
        run_to(2, 1);
        ML = 4'd7;
        run_to(3, 2);
        chk("ml_old", SEG, 8'b0_0011001);
        run_to(3, 2);
        chk("ml_new", SEG, 8'b0_1111000);
        run_to(5, 3);

        // minute blinking, then switch to seconds
        BLINK_SEL = 2'd2;
        repeat (8 * 6 * SD) tick();
        run_to(2, 3);
        BLINK_SEL = 2'd3;
        repeat (5 * 6 * SD) tick();
        BLINK_SEL = 2'd0;

        // out-of-range minute units shows a dash
        ML = 4'hC;
        run_to(5, 3);
        run_to(3, 2);
        chk("dash", SEG, 8'b0_0111111);

        // asynchronous reset mid-slot 2
        run_to(2, 2);
        #2;
        RST = 1'b0;
        set_time(2, 3, 5, 9, 5, 8);
        #1;
        chk("arst_dig", {2'b00, DIGIT}, 8'h3F);
        chk("arst_seg", SEG, 8'hFF);
        model_reset();
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        run_to(0, 2);
        chk("rst2_s0_seg", SEG, 8'b1_0100100);
        chk("rst2_s0_dig", {2'b00, DIGIT}, 8'b00_111110);
        run_to(3, 2);
        chk("rst2_s3_seg", SEG, 8'b0_0010000);

        // randomized inputs and blink selections
        for (int i = 0; i < 1200; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                HH = 2'($urandom_range(0, 3));
                HL = 4'($urandom);
                MH = 3'($urandom);
                ML = 4'($urandom);
                SH = 3'($urandom);
                SL = 4'($urandom);
            end
            if ($urandom_range(0, 59) == 0) BLINK_SEL = 2'($urandom);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
